// File: rtl/s2_sample_accumulator.sv
// ---------------------------------------------------------------------------
// s2_sample_accumulator
//
// Purpose:
//   Downstream consumer of the S2 mux-register stage. It collects a burst of
//   DEPTH = 2**LOGD qualified samples. For that burst it produces the running
//   sum, a shift-based average, and the maximum and minimum sample. A
//   busy/done handshake reports progress to the controlling logic.
//
// Parameters:
//   N     - sample width; must match the S2 stage output width
//   LOGD  - log2 of the burst length (LOGD >= 1)
//
// Ports:
//   CLK        in   1        system clock, rising edge
//   CLR        in   1        asynchronous active-high reset, clears everything
//   start      in   1        begin a new burst (level, sampled on CLK)
//   din_valid  in   1        din is a qualified sample this cycle
//   din        in   N        sample word from the S2 stage
//   busy       out  1        high while accumulating
//   done       out  1        one-cycle pulse when the burst is complete
//   sum        out  N+LOGD   running / final sum of accepted samples
//   avg        out  N        final sum >> LOGD (truncating)
//   max_val    out  N        largest accepted sample of the burst
//   min_val    out  N        smallest accepted sample of the burst
//   cnt        out  LOGD+1   samples accepted in the current burst
// ---------------------------------------------------------------------------
module s2_sample_accumulator #(
  parameter int N    = 5,
  parameter int LOGD = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic              din_valid,
  input  logic [N-1:0]      din,
  output logic              busy,
  output logic              done,
  output logic [N+LOGD-1:0] sum,
  output logic [N-1:0]      avg,
  output logic [N-1:0]      max_val,
  output logic [N-1:0]      min_val,
  output logic [LOGD:0]     cnt
);

  localparam int SW    = N + LOGD;
  localparam int CW    = LOGD + 1;
  localparam int DEPTH = 1 << LOGD;

  // Count value at which the next accepted sample completes the burst.
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [N-1:0]    avg_q, avg_d;
  logic [N-1:0]    max_q, max_d;
  logic [N-1:0]    min_q, min_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [SW-1:0]   sum_acc;
  logic            burst_begin;

  // Sum including the current sample. SW bits cannot overflow for DEPTH
  // samples of N bits, so no saturation is needed.
  assign sum_acc = sum_q + {{LOGD{1'b0}}, din};

  // A new burst can only be launched from IDLE or straight out of DONE.
  // In ACC the start input is deliberately ignored.
  assign burst_begin = start && ((state_q == IDLE) || (state_q == DONE));

  // State and result registers. Every output comes from one of these flops.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      sum_q   <= '0;
      avg_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      avg_q   <= avg_d;
      max_q   <= max_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-result logic. Results hold unless something below
  // updates them. This keeps the previous burst visible in IDLE.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    avg_d   = avg_q;
    max_d   = max_q;
    min_d   = min_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
        end
      end

      ACC: begin
        if (din_valid) begin
          sum_d = sum_acc;
          cnt_d = cnt_q + 1'b1;
          if (din > max_q) begin
            max_d = din;
          end
          if (din < min_q) begin
            min_d = din;
          end
          if (cnt_q == LAST_CNT) begin
            // The average is taken from the sum that includes this final
            // sample, so it is ready on the same edge as done.
            avg_d   = sum_acc[SW-1:LOGD];
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = start ? ACC : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Clearing on burst start overrides the holds above. Min starts at all
    // ones so that the first accepted sample always replaces it. Samples
    // seen on the start cycle are therefore never accumulated.
    if (burst_begin) begin
      sum_d = '0;
      cnt_d = '0;
      avg_d = '0;
      max_d = '0;
      min_d = '1;
    end
  end

  // The handshake flags follow the state being entered. This lets them
  // change on the same edge as the state register.
  always_comb begin
    busy_d = (state_d == ACC);
    done_d = (state_d == DONE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign avg     = avg_q;
  assign max_val = max_q;
  assign min_val = min_q;
  assign cnt     = cnt_q;

endmodule
